// File: rtl/dmem_pkg.sv
// Shared types and width defaults for the data-memory access controller.
// Optional feature macro used by the controller: DMEM_STORE_BUF_EN.
package dmem_pkg;

    localparam int DMEM_AW = 32;
    localparam int DMEM_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    // One latched bus request: direction, byte address and store data.
    typedef struct packed {
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_store_buf.sv
// One-entry posted store buffer. An entry is pushed from the controller's
// IDLE state and leaves when the bus grants its drain request. Only
// instantiated when DMEM_STORE_BUF_EN is defined.
module dmem_store_buf
    import dmem_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [DMEM_AW-1:0] push_addr_i,
    input  logic [DMEM_DW-1:0] push_wdata_i,
    input  logic               gnt_i,
    output logic               full_o,
    output logic [DMEM_AW-1:0] addr_o,
    output logic [DMEM_DW-1:0] wdata_o
);

    logic      full_q, full_d;
    dmem_req_t entry_q, entry_d;

    // Next-state: a push fills the entry, a grant while full empties it.
    always_comb begin
        full_d  = full_q;
        entry_d = entry_q;
        if (push_i) begin
            full_d        = 1'b1;
            entry_d.we    = 1'b1;
            entry_d.addr  = push_addr_i;
            entry_d.wdata = push_wdata_i;
        end else if (full_q && gnt_i) begin
            full_d = 1'b0;
        end
    end

    // Buffer registers; reset empties the buffer and clears its contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            full_q  <= full_d;
            entry_q <= entry_d;
        end
    end

    assign full_o  = full_q;
    assign addr_o  = entry_q.addr;
    assign wdata_o = entry_q.wdata;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller downstream of the MEM stage: turns the
// single-cycle MEM request into a req/gnt/rvalid bus transaction and holds
// stallM while it is outstanding. AW/DW must not exceed the dmem_pkg widths.
// Optional feature: define DMEM_STORE_BUF_EN for a one-entry posted store
// buffer that lets stores retire without stalling.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memreadM,
    input  logic          memwriteM,
    input  logic [AW-1:0] dmem_addr,
    input  logic [DW-1:0] dmem_wd,
    output logic [DW-1:0] dmem_rd,
    output logic          stallM,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_gnt,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata
);

    dmem_state_t        state_q, state_d;
    dmem_req_t          req_q, req_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               access;
    logic               fsm_start;
    logic               sel_we;
    logic [DMEM_AW-1:0] sel_addr;
    logic [DMEM_DW-1:0] sel_wdata;

    assign access = memreadM | memwriteM;

`ifdef DMEM_STORE_BUF_EN
    logic               buf_full;
    logic               buf_push;
    logic [DMEM_AW-1:0] buf_addr;
    logic [DMEM_DW-1:0] buf_wdata;

    // A pure store seen in IDLE with an empty buffer is posted and retires
    // at once. Anything else waits for the buffer to drain; the FSM only
    // leaves IDLE with the buffer empty, so the two never share the bus.
    assign buf_push  = (state_q == IDLE) && memwriteM && !memreadM && !buf_full;
    assign fsm_start = access && !buf_full && !buf_push;

    dmem_store_buf u_store_buf (
        .clk          (clk),
        .reset        (reset),
        .push_i       (buf_push),
        .push_addr_i  (DMEM_AW'(dmem_addr)),
        .push_wdata_i (DMEM_DW'(dmem_wd)),
        .gnt_i        (bus_gnt),
        .full_o       (buf_full),
        .addr_o       (buf_addr),
        .wdata_o      (buf_wdata)
    );

    assign bus_req   = buf_full || (state_q == REQ);
    assign sel_we    = buf_full ? 1'b1 : req_q.we;
    assign sel_addr  = buf_full ? buf_addr : req_q.addr;
    assign sel_wdata = buf_full ? buf_wdata : req_q.wdata;
    assign stallM    = access && (state_q != DONE) && !buf_push;
`else
    assign fsm_start = access;
    assign bus_req   = (state_q == REQ);
    assign sel_we    = req_q.we;
    assign sel_addr  = req_q.addr;
    assign sel_wdata = req_q.wdata;
    assign stallM    = access && (state_q != DONE);
`endif

    // Bus address is always word aligned; the raw byte address is latched.
    assign bus_we    = sel_we;
    assign bus_addr  = AW'(sel_addr) & ~AW'(3);
    assign bus_wdata = DW'(sel_wdata);
    assign dmem_rd   = rdata_q;

    // Next-state and latch updates; a simultaneous read+write is a read.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (fsm_start) begin
                    req_d.we    = memwriteM && !memreadM;
                    req_d.addr  = DMEM_AW'(dmem_addr);
                    req_d.wdata = DMEM_DW'(dmem_wd);
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_d = req_q.we ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    rdata_d = bus_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request/response latches with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
